// File: rtl/lsu_dbus.sv
// rtl/lsu_dbus.sv - load/store unit driving a word-addressed request/ack data bus (optional LSU_MISALIGN_TRAP_EN)
module lsu_dbus #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write_en,
    input  logic        load_en,
    input  logic [2:0]  S_type_data,
    input  logic [2:0]  L_type_data,
    input  logic [31:0] alu_addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [2:0]    code_q;
    logic [1:0]    lo_q;
    logic          access;
    logic          size_ok;
    logic          is_half;
    logic          is_word;
    logic          misalign;
    logic          go_bus;
    logic          timeout_hit;
    logic [3:0]    be_calc;
    logic [31:0]   wdata_calc;

    // Pull the addressed lane out of the read word and extend it per the load code
    function automatic logic [31:0] extract(input logic [2:0] code, input logic [1:0] lo,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (code)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign access      = mem_write_en | load_en;
    assign timeout_hit = (count == CW'(TIMEOUT - 1));

    // Decode the incoming size code; stores take priority, unknown codes (incl. X) fall to default
    always_comb begin
        size_ok = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        if (mem_write_en) begin
            case (S_type_data)
                3'b000:  size_ok = 1'b1;
                3'b001:  begin size_ok = 1'b1; is_half = 1'b1; end
                3'b010:  begin size_ok = 1'b1; is_word = 1'b1; end
                default: size_ok = 1'b0;
            endcase
        end else begin
            case (L_type_data)
                3'b000, 3'b100: size_ok = 1'b1;
                3'b001, 3'b101: begin size_ok = 1'b1; is_half = 1'b1; end
                3'b010:         begin size_ok = 1'b1; is_word = 1'b1; end
                default:        size_ok = 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (is_half & alu_addr[0]) | (is_word & (alu_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign go_bus = size_ok & ~misalign;

    // Byte enables and lane-replicated write data; low address bits below the access size are ignored
    always_comb begin
        be_calc    = 4'b0001 << alu_addr[1:0];
        wdata_calc = {4{store_data[7:0]}};
        if (is_word) begin
            be_calc    = 4'b1111;
            wdata_calc = store_data;
        end else if (is_half) begin
            be_calc    = alu_addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{store_data[15:0]}};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and stall generation
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = access;
                if (access) state_next = go_bus ? REQ : DONE;
            end
            REQ: begin
                stall = 1'b1;
                if (dbus_ack || timeout_hit) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus fields, timeout counter, load result and error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'd0;
            dbus_be    <= 4'd0;
            dbus_wdata <= 32'd0;
            load_data  <= 32'd0;
            bus_err    <= 1'b0;
            count      <= '0;
            code_q     <= 3'd0;
            lo_q       <= 2'd0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (access) begin
                        if (go_bus) begin
                            dbus_req   <= 1'b1;
                            dbus_we    <= mem_write_en;
                            dbus_addr  <= {alu_addr[31:2], 2'b00};
                            dbus_be    <= be_calc;
                            dbus_wdata <= wdata_calc;
                            code_q     <= L_type_data;
                            lo_q       <= alu_addr[1:0];
                        end else begin
                            load_data <= 32'd0;
                            bus_err   <= misalign;
                        end
                    end
                end
                REQ: begin
                    if (dbus_ack) begin
                        dbus_req  <= 1'b0;
                        load_data <= dbus_we ? 32'd0 : extract(code_q, lo_q, dbus_rdata);
                    end else if (timeout_hit) begin
                        dbus_req  <= 1'b0;
                        bus_err   <= 1'b1;
                        load_data <= 32'd0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: count <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dbus.sv
// tb/tb_lsu_dbus.sv - directed and randomized checks of lsu_dbus against a behavioural model
module tb_lsu_dbus;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write_en = 1'b0;
    logic        load_en = 1'b0;
    logic [2:0]  S_type_data = 3'd0;
    logic [2:0]  L_type_data = 3'd0;
    logic [31:0] alu_addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] load_data;
    logic        stall;
    logic        bus_err;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata = 32'd0;
    logic        dbus_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    lsu_dbus #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .mem_write_en(mem_write_en), .load_en(load_en),
        .S_type_data(S_type_data), .L_type_data(L_type_data), .alu_addr(alu_addr),
        .store_data(store_data), .load_data(load_data), .stall(stall), .bus_err(bus_err),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes (0 = undefined code) and signedness, from the instruction set table
    function automatic int size_of(input bit w, input logic [2:0] c, output bit sgn);
        sgn = 1'b0;
        if (w) begin
            if (c === 3'b000) return 1;
            if (c === 3'b001) return 2;
            if (c === 3'b010) return 4;
            return 0;
        end
        if (c === 3'b000) begin sgn = 1'b1; return 1; end
        if (c === 3'b001) begin sgn = 1'b1; return 2; end
        if (c === 3'b010) return 4;
        if (c === 3'b100) return 1;
        if (c === 3'b101) return 2;
        return 0;
    endfunction

    function automatic bit trapped(input int sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % sz) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Aligned lane offset in bytes of the access within its word
    function automatic int lane_off(input int sz, input logic [31:0] a);
        return (a % 4) / sz * sz;
    endfunction

    function automatic logic [31:0] exp_be(input int sz, input logic [31:0] a);
        logic [31:0] ones;
        ones = (32'd1 << sz) - 1;
        return ones << lane_off(sz, a);
    endfunction

    function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input int sz, input bit sgn, input logic [31:0] a,
                                             input logic [31:0] r);
        logic [31:0] mask;
        logic [31:0] v;
        if (sz == 4) return r;
        mask = (32'd1 << (8 * sz)) - 1;
        v = (r >> (8 * lane_off(sz, a))) & mask;
        if (sgn && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    // One memory instruction from the IDLE cycle through DONE, ack after wait_n wait cycles
    task automatic access(input bit w, input bit both, input logic [2:0] code, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] r, input int wait_n);
        bit          sgn;
        int          sz;
        int          ereq, estall, stall_cnt, req_cnt, early_err, cyc;
        bit          eerr, done, timed_out;
        logic [31:0] eld;
        sz = size_of(w, code, sgn);
        timed_out = 1'b0;
        if (sz == 0) begin
            ereq = 0; estall = 1; eld = 0; eerr = 1'b0;
        end else if (trapped(sz, a)) begin
            ereq = 0; estall = 1; eld = 0; eerr = 1'b1;
        end else if (wait_n >= TMO) begin
            ereq = TMO; estall = TMO + 1; eld = 0; eerr = 1'b1; timed_out = 1'b1;
        end else begin
            ereq = wait_n + 1; estall = wait_n + 2; eerr = 1'b0;
            eld = exp_load(sz, sgn, a, r);
        end
        mem_write_en = w;
        load_en      = !w || both;
        S_type_data  = w ? code : 3'($urandom_range(0, 7));
        L_type_data  = w ? 3'($urandom_range(0, 7)) : code;
        alu_addr     = a;
        store_data   = d;
        dbus_rdata   = r;
        dbus_ack     = 1'b0;
        stall_cnt = 0; req_cnt = 0; early_err = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            #1;
            if (cyc > 0 && stall === 1'b0) begin
                done = 1'b1;
            end else begin
                if (stall === 1'b1) stall_cnt++;
                if (bus_err !== 1'b0) early_err++;
                if (cyc == 0) check("idle_no_req", {31'd0, dbus_req}, 32'd0);
                if (dbus_req === 1'b1) begin
                    req_cnt++;
                    check("req_we", {31'd0, dbus_we}, {31'd0, w});
                    check("req_addr", dbus_addr, a & 32'hFFFF_FFFC);
                    if (w) begin
                        check("req_be", {28'd0, dbus_be}, exp_be(sz, a));
                        check("req_wdata", dbus_wdata, exp_wdata(sz, d));
                    end
                    dbus_ack = (req_cnt == wait_n + 1);
                end else begin
                    dbus_ack = 1'b0;
                end
                @(negedge clk);
            end
            cyc++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
        check("stall_cycles", stall_cnt, estall);
        check("req_cycles", req_cnt, ereq);
        check("err_before_done", early_err, 0);
        check("done_bus_err", {31'd0, bus_err}, {31'd0, eerr});
        check("done_req_low", {31'd0, dbus_req}, 32'd0);
        if (!w) check("done_load_data", load_data, eld);
        mem_write_en = 1'b0;
        load_en      = 1'b0;
        dbus_ack     = timed_out;
        @(negedge clk);
        #1;
        check("after_stall", {31'd0, stall}, 32'd0);
        check("after_req", {31'd0, dbus_req}, 32'd0);
        check("after_err", {31'd0, bus_err}, 32'd0);
        if (timed_out) check("late_ack_ignored", load_data, 32'd0);
        dbus_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset values while reset is held
        #2;
        check("rst_req", {31'd0, dbus_req}, 32'd0);
        check("rst_we", {31'd0, dbus_we}, 32'd0);
        check("rst_addr", dbus_addr, 32'd0);
        check("rst_be", {28'd0, dbus_be}, 32'd0);
        check("rst_wdata", dbus_wdata, 32'd0);
        check("rst_load", load_data, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Non-memory instructions do not stall
        for (int i = 0; i < 3; i++) begin
            #1;
            check("nomem_stall", {31'd0, stall}, 32'd0);
            check("nomem_req", {31'd0, dbus_req}, 32'd0);
            @(negedge clk);
        end

        access(1'b1, 1'b0, 3'b010, 32'h0000_1006, 32'hDEAD_BEEF, 32'd0, 0);
        access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'd0, 0);
        access(1'b0, 1'b0, 3'b000, 32'h0000_0202, 32'd0, 32'h0080_0000, 0);
        check("lb_value", load_data, 32'hFFFF_FF80);
        access(1'b0, 1'b0, 3'b100, 32'h0000_0202, 32'd0, 32'h0080_0000, 1);
        check("lbu_value", load_data, 32'h0000_0080);
        access(1'b0, 1'b0, 3'b001, 32'h0000_0302, 32'd0, 32'h8001_1234, 3);
        access(1'b0, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h1234_5678, 99);
        access(1'b0, 1'b0, 3'b010, 32'h0000_0404, 32'd0, 32'h1234_5678, TMO - 1);
        access(1'b0, 1'b0, 3'b111, 32'h0000_0408, 32'd0, 32'h5555_5555, 0);
        access(1'b1, 1'b0, 3'b011, 32'h0000_040C, 32'h1111_2222, 32'd0, 0);
        access(1'b1, 1'b1, 3'b001, 32'h0000_0412, 32'hCAFE_F00D, 32'd0, 2);
        access(1'b0, 1'b0, 3'b010, 32'h0000_0401, 32'd0, 32'hA5A5_0F0F, 0);
        access(1'b0, 1'b0, 3'b101, 32'h0000_0403, 32'd0, 32'hF00D_8001, 0);

        // Asynchronous reset in the middle of a request
        mem_write_en = 1'b0;
        load_en      = 1'b1;
        L_type_data  = 3'b010;
        alu_addr     = 32'h0000_0500;
        dbus_ack     = 1'b0;
        @(negedge clk);
        #1;
        check("mid_req_high", {31'd0, dbus_req}, 32'd1);
        #2;
        reset   = 1'b1;
        load_en = 1'b0;
        #1;
        check("async_req_drop", {31'd0, dbus_req}, 32'd0);
        check("async_idle", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_req", {31'd0, dbus_req}, 32'd0);
        @(negedge clk);

        // Randomized mix of loads, stores, sizes, addresses and wait states
        for (int i = 0; i < 40; i++) begin
            bit          w;
            logic [2:0]  c;
            int          pick;
            w    = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            if (w) c = (pick < 9) ? 3'(pick % 3) : 3'($urandom_range(3, 7));
            else begin
                case (pick % 6)
                    0: c = 3'b000;
                    1: c = 3'b001;
                    2: c = 3'b010;
                    3: c = 3'b100;
                    4: c = 3'b101;
                    default: c = (pick == 9) ? 3'b110 : 3'b011;
                endcase
            end
            access(w, 1'($urandom_range(0, 1)), c, $urandom, $urandom, $urandom,
                   $urandom_range(0, TMO + 1));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                #1;
                check("gap_stall", {31'd0, stall}, 32'd0);
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
